result_accumulator: RTL and testbench

RESULT_ACCUMULATOR -- requirements
Module: result_accumulator

---
 rtl/result_accumulator.sv | 105 ++++++++++
 tb/tb_result_accumulator.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/result_accumulator.sv
// Result accumulator: sums a job of LEN unsigned products into a saturating
// accumulator, then holds the sum behind a valid/ready handshake.
module result_accumulator #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 32,
  parameter int LEN_W     = 8
) (
  input  logic                 CLK,
  input  logic                 ASYNC_RST,
  input  logic                 SYNC_RST,
  input  logic                 START,
  input  logic [LEN_W-1:0]     LEN,
  input  logic                 IN_VALID,
  input  logic [2*WIDTH-1:0]   PRODUCT,
  input  logic                 OUT_READY,
  output logic                 OUT_VALID,
  output logic [ACC_WIDTH-1:0] ACC_OUT,
  output logic                 BUSY,
  output logic                 OVERFLOW
);

  // The accumulator must be able to hold at least one full product.
  if (ACC_WIDTH < 2 * WIDTH) begin : g_bad_acc_width
    $error("result_accumulator: ACC_WIDTH must be >= 2*WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t               state;
  logic [ACC_WIDTH-1:0] acc;
  logic [LEN_W-1:0]     count;
  logic                 overflow;

  logic                 accept_start;
  logic [ACC_WIDTH:0]   sum;
  logic                 sum_carry;
  logic [ACC_WIDTH-1:0] sat_sum;

  // Decide whether a START is honoured and form the saturated next sum.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    accept_start = 1'b0;
    if (START) begin
      accept_start = (state == IDLE) || ((state == HOLD) && OUT_READY);
    end
    sum       = {1'b0, acc} + {1'b0, ACC_WIDTH'(PRODUCT)};
    sum_carry = sum[ACC_WIDTH];
    sat_sum   = sum_carry ? {ACC_WIDTH{1'b1}} : sum[ACC_WIDTH-1:0];
  end

  // Job sequencing, accumulation and sticky overflow; sync reset beats all inputs.
  always_ff @(posedge CLK or negedge ASYNC_RST) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!ASYNC_RST) begin
      state    <= IDLE;
      acc      <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (SYNC_RST) begin
      state    <= IDLE;
      acc      <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (accept_start) begin
      // New job: from IDLE, or from HOLD completing the handshake this cycle.
      acc      <= '0;
      overflow <= 1'b0;
      count    <= LEN;
      state    <= (LEN == '0) ? HOLD : ACC;
    end else begin
      case (state)
        ACC: begin
          if (IN_VALID) begin
            acc   <= sat_sum;
            count <= count - LEN_W'(1);
            if (sum_carry) begin
              overflow <= 1'b1;
            end
            if (count == LEN_W'(1)) begin
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (OUT_READY) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign OUT_VALID = (state == HOLD);
  assign BUSY      = (state == ACC);
  assign ACC_OUT   = acc;
  assign OVERFLOW  = overflow;

endmodule

// File: tb/tb_result_accumulator.sv
// Directed bench for result_accumulator: a default-size instance and a
// 16-bit accumulator instance share all inputs.
module tb_result_accumulator;

  localparam int WIDTH = 8;
  localparam int LEN_W = 8;

  logic                 CLK = 1'b0;
  logic                 ASYNC_RST;
  logic                 SYNC_RST;
  logic                 START;
  logic [LEN_W-1:0]     LEN;
  logic                 IN_VALID;
  logic [2*WIDTH-1:0]   PRODUCT;
  logic                 OUT_READY;

  logic                 out_valid, busy, overflow;
  logic [31:0]          acc_out;
  logic                 out_valid16, busy16, overflow16;
  logic [15:0]          acc_out16;

  int n_tests = 0;
  int n_fail  = 0;

  result_accumulator #(.WIDTH(WIDTH), .ACC_WIDTH(32), .LEN_W(LEN_W)) dut (
    .CLK(CLK), .ASYNC_RST(ASYNC_RST), .SYNC_RST(SYNC_RST), .START(START),
    .LEN(LEN), .IN_VALID(IN_VALID), .PRODUCT(PRODUCT), .OUT_READY(OUT_READY),
    .OUT_VALID(out_valid), .ACC_OUT(acc_out), .BUSY(busy), .OVERFLOW(overflow)
  );

  result_accumulator #(.WIDTH(WIDTH), .ACC_WIDTH(16), .LEN_W(LEN_W)) dut16 (
    .CLK(CLK), .ASYNC_RST(ASYNC_RST), .SYNC_RST(SYNC_RST), .START(START),
    .LEN(LEN), .IN_VALID(IN_VALID), .PRODUCT(PRODUCT), .OUT_READY(OUT_READY),
    .OUT_VALID(out_valid16), .ACC_OUT(acc_out16), .BUSY(busy16), .OVERFLOW(overflow16)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1ns past it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic start_job(input logic [LEN_W-1:0] n, input logic rdy);
    START = 1'b1; LEN = n; OUT_READY = rdy;
    tick();
    START = 1'b0;
  endtask

  task automatic feed(input logic [15:0] p);
    IN_VALID = 1'b1; PRODUCT = p;
    tick();
    IN_VALID = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_busy"},  busy, 0);
    check({tag, "_acc"},   acc_out, 0);
    check({tag, "_ovf"},   overflow, 0);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    ASYNC_RST = 1'b0; SYNC_RST = 1'b0; START = 1'b0; LEN = '0;
    IN_VALID = 1'b0; PRODUCT = '0; OUT_READY = 1'b0;
    #12;
    check_all_zero("reset");
    check("reset_valid16", out_valid16, 0);
    ASYNC_RST = 1'b1;
    tick();

    // Basic job: 3+5+7+9 = 24.
    start_job(8'd4, 1'b1);
    check("basic_busy", busy, 1);
    feed(16'd3); feed(16'd5); feed(16'd7);
    check("basic_busy_mid", busy, 1);
    feed(16'd9);
    check("basic_valid", out_valid, 1);
    check("basic_acc", acc_out, 24);
    check("basic_ovf", overflow, 0);
    check("basic_busy_hold", busy, 0);
    tick();
    check("basic_idle_valid", out_valid, 0);
    check("basic_idle_busy", busy, 0);

    // Gapped input plus back-pressure: 3*65025 = 195075.
    start_job(8'd3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      feed(16'd65025);
      if (i < 2) begin
        check("gap_hold_state", busy, 1);
        tick();
      end
    end
    IN_VALID = 1'b1; PRODUCT = 16'd100;   // must be ignored in HOLD
    for (int i = 0; i < 5; i++) begin
      check("gap_valid", out_valid, 1);
      check("gap_acc", acc_out, 195075);
      check("gap_acc16_sat", acc_out16, 65535);
      check("gap_ovf16", overflow16, 1);
      if (i == 2) START = 1'b1;             // ignored: OUT_READY=0
      LEN = 8'd5;
      tick();
      START = 1'b0;
    end
    IN_VALID = 1'b0;
    check("gap_still_valid", out_valid, 1);
    check("gap_still_acc", acc_out, 195075);
    OUT_READY = 1'b1;
    tick();
    check("gap_accepted", out_valid, 0);
    check("gap_not_busy", busy, 0);

    // Saturation on the 16-bit instance: 65025+1000 saturates to 65535.
    start_job(8'd2, 1'b0);
    check("sat_ovf_clear16", overflow16, 0);
    feed(16'd65025);
    check("sat_partial16", acc_out16, 65025);
    check("sat_partial_ovf16", overflow16, 0);
    feed(16'd1000);
    check("sat_valid16", out_valid16, 1);
    check("sat_acc16", acc_out16, 65535);
    check("sat_ovf16", overflow16, 1);
    check("sat_acc32", acc_out, 66025);
    check("sat_ovf32", overflow, 0);
    tick();
    check("sat_ovf16_sticky", overflow16, 1);
    // Back-to-back START with handshake clears OVERFLOW.
    start_job(8'd1, 1'b1);
    check("sat_next_ovf16", overflow16, 0);
    check("sat_next_busy16", busy16, 1);
    feed(16'd1);
    check("sat_next_acc16", acc_out16, 1);
    tick();

    // Zero length job, then back-to-back LEN=1 in the handshake cycle.
    start_job(8'd0, 1'b0);
    check("zero_valid", out_valid, 1);
    check("zero_acc", acc_out, 0);
    check("zero_busy", busy, 0);
    start_job(8'd1, 1'b1);
    check("b2b_busy", busy, 1);
    check("b2b_valid", out_valid, 0);
    OUT_READY = 1'b0;
    feed(16'd42);
    check("b2b_valid_done", out_valid, 1);
    check("b2b_acc", acc_out, 42);
    OUT_READY = 1'b1;
    tick();
    check("b2b_idle", out_valid, 0);

    // START mid-job is ignored; job still ends after 2 products.
    start_job(8'd2, 1'b1);
    START = 1'b1; LEN = 8'd9;
    feed(16'd10);
    START = 1'b0;
    check("ign_busy", busy, 1);
    check("ign_acc", acc_out, 10);
    feed(16'd20);
    check("ign_valid", out_valid, 1);
    check("ign_acc_done", acc_out, 30);
    tick();

    // Async reset after 2 of 4 products.
    start_job(8'd4, 1'b0);
    feed(16'd1); feed(16'd2);
    #2;
    ASYNC_RST = 1'b0;
    #1;
    check_all_zero("arst");
    @(negedge CLK);
    ASYNC_RST = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      feed(16'd7);
      check("arst_no_valid", out_valid, 0);
    end

    // Sync reset after 2 of 4 products, with START asserted to test priority.
    start_job(8'd4, 1'b0);
    feed(16'd1); feed(16'd2);
    SYNC_RST = 1'b1; START = 1'b1; LEN = 8'd3;
    tick();
    SYNC_RST = 1'b0; START = 1'b0;
    check_all_zero("srst");
    for (int i = 0; i < 4; i++) begin
      feed(16'd7);
      check("srst_no_valid", out_valid, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
